// File: rtl/ldr_region_decoder.sv
// ldr_region_decoder
//   Registered load-path decoder between the LDR stage and memory-mapped load
//   targets. Each accepted load address is matched against N_REG inclusive
//   windows (lowest index wins on overlap). The request goes out to the
//   matching target, the decoder waits for that target's acknowledge, and the
//   data comes back with a one-cycle ld_valid strobe. Unmapped addresses are
//   answered immediately with an error response.
//
//   Optional build macro: LDR_TIMEOUT_EN
//     When defined, a WAIT that lasts TIMEOUT cycles without an acknowledge
//     is abandoned and answered with an error response for that region.
//
//   Ports
//     clk, rst              clock (rising edge), synchronous active-high reset
//     ld_req, ld_addr       load request and byte address from the processor
//     ld_ready              decoder idle and able to accept a request
//     ld_valid              one-cycle response strobe
//     ld_data, ld_err       response data (0 on error) and error flag
//     ld_region             matched region index, all-ones when unmapped
//     tgt_sel, tgt_req      one-hot target select and request
//     tgt_addr              offset of the load address within its region
//     tgt_ack, tgt_rdata    per-target acknowledge and read data
//
//   state | meaning
//   IDLE  | ready for a new load
//   WAIT  | request outstanding to the selected target
//   RESP  | ld_valid strobe, response fields valid
module ldr_region_decoder #(
  parameter int                      ADDR_W    = 32,
  parameter int                      DATA_W    = 32,
  parameter int                      N_REG     = 2,
  parameter logic [N_REG*ADDR_W-1:0] REG_BASE  = {32'd1036, 32'd0},
  parameter logic [N_REG*ADDR_W-1:0] REG_LIMIT = {32'd1039, 32'd1023},
  parameter int                      TIMEOUT   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_req,
  input  logic [ADDR_W-1:0]         ld_addr,
  output logic                      ld_ready,
  output logic                      ld_valid,
  output logic [DATA_W-1:0]         ld_data,
  output logic                      ld_err,
  output logic [$clog2(N_REG):0]    ld_region,
  output logic [N_REG-1:0]          tgt_sel,
  output logic                      tgt_req,
  output logic [ADDR_W-1:0]         tgt_addr,
  input  logic [N_REG-1:0]          tgt_ack,
  input  logic [N_REG*DATA_W-1:0]   tgt_rdata
);

  localparam int RW = $clog2(N_REG) + 1;

  if (N_REG < 1 || N_REG > 8 || TIMEOUT < 1 || TIMEOUT > 256) begin : g_param_chk
    $error("ldr_region_decoder: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [N_REG-1:0]    r_sel, w_sel_nxt;
  logic                r_req, w_req_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic                r_err, w_err_nxt;
  logic [RW-1:0]       r_region, w_region_nxt;
  logic [RW-1:0]       r_idx, w_idx_nxt;

  logic                w_hit;
  logic [RW-1:0]       w_idx;
  logic [ADDR_W-1:0]   w_off;
  logic                w_ack;
  logic [DATA_W-1:0]   w_rdata;

`ifdef LDR_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]          r_cnt, w_cnt_nxt;
`endif

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    w_off = '0;
    for (int i = N_REG - 1; i >= 0; i--) begin
      if (ld_addr >= REG_BASE[i*ADDR_W +: ADDR_W] &&
          ld_addr <= REG_LIMIT[i*ADDR_W +: ADDR_W]) begin
        w_hit = 1'b1;
        w_idx = RW'(i);
        w_off = ld_addr - REG_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Only the selected target's ack and data count; r_sel is one-hot in WAIT.
  always_comb begin
    w_ack   = |(tgt_ack & r_sel);
    w_rdata = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (r_sel[i]) w_rdata = tgt_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_req_nxt    = r_req;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_err_nxt    = r_err;
    w_region_nxt = r_region;
    w_idx_nxt    = r_idx;
`ifdef LDR_TIMEOUT_EN
    w_cnt_nxt    = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (ld_req) begin
          if (w_hit) begin
            w_state_nxt = S_WAIT;
            w_sel_nxt   = N_REG'(1) << w_idx;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = w_off;
            w_idx_nxt   = w_idx;
`ifdef LDR_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
          end else begin
            w_state_nxt  = S_RESP;
            w_err_nxt    = 1'b1;
            w_data_nxt   = '0;
            w_region_nxt = '1;
          end
        end
      end
      S_WAIT: begin
        if (w_ack) begin
          w_state_nxt  = S_RESP;
          w_data_nxt   = w_rdata;
          w_err_nxt    = 1'b0;
          w_region_nxt = r_idx;
          w_sel_nxt    = '0;
          w_req_nxt    = 1'b0;
        end
`ifdef LDR_TIMEOUT_EN
        else if (r_cnt == TO_LAST) begin
          w_state_nxt  = S_RESP;
          w_data_nxt   = '0;
          w_err_nxt    = 1'b1;
          w_region_nxt = r_idx;
          w_sel_nxt    = '0;
          w_req_nxt    = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
`endif
      end
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_req    <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
      r_region <= '1;
      r_idx    <= '0;
`ifdef LDR_TIMEOUT_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_req    <= w_req_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_err    <= w_err_nxt;
      r_region <= w_region_nxt;
      r_idx    <= w_idx_nxt;
`ifdef LDR_TIMEOUT_EN
      r_cnt    <= w_cnt_nxt;
`endif
    end
  end

  assign ld_ready  = (r_state == S_IDLE);
  assign ld_valid  = (r_state == S_RESP);
  assign ld_data   = r_data;
  assign ld_err    = r_err;
  assign ld_region = r_region;
  assign tgt_sel   = r_sel;
  assign tgt_req   = r_req;
  assign tgt_addr  = r_addr;

endmodule

// File: tb/tb_ldr_region_decoder.sv
module tb_ldr_region_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_ready;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_err;
  logic [1:0]  ld_region;
  logic [1:0]  tgt_sel;
  logic        tgt_req;
  logic [31:0] tgt_addr;
  logic [1:0]  tgt_ack;
  logic [63:0] tgt_rdata;

  int n_chk = 0;
  int n_err = 0;

  ldr_region_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_ready  (ld_ready),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_err    (ld_err),
    .ld_region (ld_region),
    .tgt_sel   (tgt_sel),
    .tgt_req   (tgt_req),
    .tgt_addr  (tgt_addr),
    .tgt_ack   (tgt_ack),
    .tgt_rdata (tgt_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          delay;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        mapped;
    logic [1:0]  sel;
    logic [31:0] taddr;
    logic [31:0] data;
    logic [1:0]  region;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called just after a negedge with the decoder in IDLE.
  task automatic run_vec(input vec_t v, input string tag);
    ld_addr = v.addr;
    ld_req  = 1'b1;
    chk({tag, " ready_before"}, 64'(ld_ready), 64'd1);
    @(negedge clk);
    ld_req = 1'b0;
    if (v.mapped) begin
      chk({tag, " tgt_req"},  64'(tgt_req),  64'd1);
      chk({tag, " tgt_sel"},  64'(tgt_sel),  64'(v.sel));
      chk({tag, " tgt_addr"}, 64'(tgt_addr), 64'(v.taddr));
      chk({tag, " ready_busy"}, 64'(ld_ready), 64'd0);
      chk({tag, " valid_early"}, 64'(ld_valid), 64'd0);
      for (int k = 0; k < v.delay; k++) begin
        @(negedge clk);
        chk({tag, " tgt_req_hold"}, 64'(tgt_req), 64'd1);
      end
      tgt_rdata = {v.rd1, v.rd0};
      tgt_ack   = v.sel;
      @(negedge clk);
      tgt_ack = 2'b00;
    end
    chk({tag, " valid"},  64'(ld_valid),  64'd1);
    chk({tag, " data"},   64'(ld_data),   64'(v.data));
    chk({tag, " err"},    64'(ld_err),    64'(!v.mapped));
    chk({tag, " region"}, 64'(ld_region), 64'(v.region));
    chk({tag, " req_drop"}, 64'(tgt_req), 64'd0);
    chk({tag, " sel_drop"}, 64'(tgt_sel), 64'd0);
    @(negedge clk);
    chk({tag, " valid_once"}, 64'(ld_valid), 64'd0);
    chk({tag, " ready_after"}, 64'(ld_ready), 64'd1);
    chk({tag, " data_hold"}, 64'(ld_data), 64'(v.data));
  endtask

  vec_t vecs[10];
  int   vcnt;

  initial begin
    rst       = 1'b1;
    ld_req    = 1'b0;
    ld_addr   = '0;
    tgt_ack   = 2'b00;
    tgt_rdata = '0;

    //           addr          dly rd0            rd1            map sel    taddr         data           region
    vecs[0] = '{32'h0000_0010, 1, 32'hDEAD_BEEF, 32'h0000_0077, 1, 2'b01, 32'h10,       32'hDEAD_BEEF, 2'd0};
    vecs[1] = '{32'd1036,      0, 32'h1111_1111, 32'h0000_0041, 1, 2'b10, 32'd0,        32'h0000_0041, 2'd1};
    vecs[2] = '{32'd1039,      2, 32'h2222_2222, 32'h0000_0041, 1, 2'b10, 32'd3,        32'h0000_0041, 2'd1};
    vecs[3] = '{32'd1023,      0, 32'h1234_5678, 32'h9999_9999, 1, 2'b01, 32'd1023,     32'h1234_5678, 2'd0};
    vecs[4] = '{32'd1024,      0, 32'h0,         32'h0,         0, 2'b00, 32'd0,        32'h0,         2'd3};
    vecs[5] = '{32'd1040,      0, 32'h0,         32'h0,         0, 2'b00, 32'd0,        32'h0,         2'd3};
    vecs[6] = '{32'd1030,      0, 32'h0,         32'h0,         0, 2'b00, 32'd0,        32'h0,         2'd3};
    vecs[7] = '{32'h0000_0000, 3, 32'hA5A5_0000, 32'h5A5A_FFFF, 1, 2'b01, 32'd0,        32'hA5A5_0000, 2'd0};
    vecs[8] = '{32'hFFFF_FFFF, 0, 32'h0,         32'h0,         0, 2'b00, 32'd0,        32'h0,         2'd3};
    vecs[9] = '{32'd1037,      1, 32'hCAFE_0000, 32'h0000_00C3, 1, 2'b10, 32'd1,        32'h0000_00C3, 2'd1};
    vcnt = 10;

    repeat (2) @(negedge clk);
    chk("rst ready",    64'(ld_ready),  64'd1);
    chk("rst valid",    64'(ld_valid),  64'd0);
    chk("rst err",      64'(ld_err),    64'd0);
    chk("rst data",     64'(ld_data),   64'd0);
    chk("rst region",   64'(ld_region), 64'd3);
    chk("rst tgt_sel",  64'(tgt_sel),   64'd0);
    chk("rst tgt_req",  64'(tgt_req),   64'd0);
    chk("rst tgt_addr", 64'(tgt_addr),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vcnt; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Ack from a non-selected target is ignored.
    ld_addr = 32'd1036;
    ld_req  = 1'b1;
    @(negedge clk);
    ld_req    = 1'b0;
    tgt_rdata = {32'h0000_0041, 32'h0000_0BAD};
    tgt_ack   = 2'b01;
    @(negedge clk);
    tgt_ack = 2'b00;
    chk("wrong_ack req",   64'(tgt_req),  64'd1);
    chk("wrong_ack sel",   64'(tgt_sel),  64'd2);
    chk("wrong_ack valid", 64'(ld_valid), 64'd0);
    repeat (2) @(negedge clk);
    tgt_ack = 2'b10;
    @(negedge clk);
    tgt_ack = 2'b00;
    chk("wrong_ack resp valid",  64'(ld_valid),  64'd1);
    chk("wrong_ack resp data",   64'(ld_data),   64'h41);
    chk("wrong_ack resp region", 64'(ld_region), 64'd1);
    chk("wrong_ack resp err",    64'(ld_err),    64'd0);
    @(negedge clk);

    // Request held across a busy period: re-accepted on the first IDLE cycle.
    ld_addr = 32'd1030;
    ld_req  = 1'b1;
    @(negedge clk);
    chk("held r1 valid", 64'(ld_valid), 64'd1);
    chk("held r1 ready", 64'(ld_ready), 64'd0);
    @(negedge clk);
    chk("held idle valid", 64'(ld_valid), 64'd0);
    chk("held idle ready", 64'(ld_ready), 64'd1);
    @(negedge clk);
    ld_req = 1'b0;
    chk("held r2 valid", 64'(ld_valid), 64'd1);
    chk("held r2 err",   64'(ld_err),   64'd1);
    @(negedge clk);

    // No acknowledge at all.
    begin
      int vseen;
      vseen   = 0;
      ld_addr = 32'd1036;
      ld_req  = 1'b1;
      @(negedge clk);
      ld_req = 1'b0;
`ifdef LDR_TIMEOUT_EN
      for (int k = 2; k <= 16; k++) begin
        @(negedge clk);
        if (ld_valid) vseen++;
      end
      chk("to no_early_valid", 64'(vseen), 64'd0);
      chk("to req_before",     64'(tgt_req), 64'd1);
      @(negedge clk);
      chk("to valid",   64'(ld_valid),  64'd1);
      chk("to err",     64'(ld_err),    64'd1);
      chk("to region",  64'(ld_region), 64'd1);
      chk("to data",    64'(ld_data),   64'd0);
      chk("to tgt_req", 64'(tgt_req),   64'd0);
      chk("to tgt_sel", 64'(tgt_sel),   64'd0);
      @(negedge clk);
      chk("to idle", 64'(ld_ready), 64'd1);
`else
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (ld_valid) vseen++;
      end
      chk("noto valid_seen", 64'(vseen),    64'd0);
      chk("noto tgt_req",    64'(tgt_req),  64'd1);
      chk("noto ready",      64'(ld_ready), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("noto recover", 64'(ld_ready), 64'd1);
`endif
    end
    @(negedge clk);

    // Reset pulse during WAIT, with an ack arriving in the reset cycle.
    ld_addr = 32'd1036;
    ld_req  = 1'b1;
    @(negedge clk);
    ld_req    = 1'b0;
    chk("rstw in_wait", 64'(tgt_req), 64'd1);
    rst       = 1'b1;
    tgt_ack   = 2'b10;
    tgt_rdata = {32'h0000_0099, 32'h0};
    @(negedge clk);
    rst     = 1'b0;
    tgt_ack = 2'b00;
    chk("rstw ready",    64'(ld_ready),  64'd1);
    chk("rstw tgt_req",  64'(tgt_req),   64'd0);
    chk("rstw tgt_sel",  64'(tgt_sel),   64'd0);
    chk("rstw valid",    64'(ld_valid),  64'd0);
    chk("rstw data",     64'(ld_data),   64'd0);
    chk("rstw region",   64'(ld_region), 64'd3);
    chk("rstw tgt_addr", 64'(tgt_addr),  64'd0);
    @(negedge clk);
    chk("rstw no_valid", 64'(ld_valid), 64'd0);
    begin
      vec_t v;
      v = '{32'h0000_0004, 1, 32'h0BAD_F00D, 32'h0000_0001, 1, 2'b01, 32'd4, 32'h0BAD_F00D, 2'd0};
      run_vec(v, "post_rst");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ldr_region_decoder.md
Name: ldr_region_decoder

Overview:
- Parametrised, registered load-path decoder between the processor's LDR stage and its memory-mapped load targets (data memory, PS/2 port, further peripherals).
- Decodes each load address against N_REG inclusive address windows and forwards the request to the matching target.
- Waits for that target's acknowledge, then returns data to the processor with a one-cycle valid pulse.
- Unmapped addresses, and timeouts when compiled in, are reported as errors instead of being silently dropped.

Parameters:
- ADDR_W, 32, load address width (unsigned).
- DATA_W, 32, load data width.
- N_REG, 2, number of decoded regions/targets (1..8).
- REG_BASE, {32'd1036, 32'd0}, packed N_REG x ADDR_W region base addresses (index 0 in LSBs): region0 = memory, region1 = PS/2.
- REG_LIMIT, {32'd1039, 32'd1023}, packed N_REG x ADDR_W inclusive upper bounds.
- TIMEOUT, 16, maximum WAIT cycles before error (used only with the macro).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous, active-high reset.
- ld_req, input, 1, processor load request.
- ld_addr, input, ADDR_W, load byte address.
- ld_ready, output, 1, decoder can accept a request.
- ld_valid, output, 1, one-cycle response strobe.
- ld_data, output, DATA_W, response data; 0 on error.
- ld_err, output, 1, response is an error; qualified by ld_valid.
- ld_region, output, $clog2(N_REG)+1, index of the matched region; all-ones if unmapped; qualified by ld_valid.
- tgt_sel, output, N_REG, one-hot target select.
- tgt_req, output, 1, request to the selected target.
- tgt_addr, output, ADDR_W, offset within the region (ld_addr - REG_BASE[i]).
- tgt_ack, input, N_REG, per-target acknowledge.
- tgt_rdata, input, N_REG*DATA_W, per-target read data; target i in slice [i*DATA_W +: DATA_W].

Behaviour:
- Reset: state=IDLE, ld_ready=1, ld_valid=0, ld_err=0, ld_data=0, ld_region=all-ones, tgt_sel=0, tgt_req=0, tgt_addr=0, timeout counter=0.
- Decode: region i matches when REG_BASE[i] <= ld_addr <= REG_LIMIT[i], both ends inclusive, unsigned compare. On overlap, the lowest index wins. No match means unmapped.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: ld_ready=1. Accept occurs on ld_req && ld_ready. At accept, register decode result and offset.
    - Mapped: next state WAIT; tgt_sel=onehot(i), tgt_req=1, tgt_addr=offset.
    - Unmapped: next state RESP; ld_err=1, ld_data=0, ld_region=all-ones.
  - WAIT: ld_ready=0. tgt_req and tgt_sel are held stable until tgt_ack[i] is seen for the selected i.
    - On ack: capture tgt_rdata slice i into ld_data, ld_err=0, ld_region=i; tgt_req and tgt_sel drop; next state RESP.
    - Ack bits of non-selected targets are ignored.
  - RESP: ld_valid=1 for exactly one cycle; ld_ready=0; next state IDLE. ld_data, ld_err and ld_region hold their values until the next response.
- Latency:
  - Mapped load: accept at edge N; tgt_req high in cycle N+1. An ack seen at edge N+1 gives ld_valid in cycle N+2.
  - Unmapped load: ld_valid in cycle N+1.
- Throughput: ld_ready is low from the cycle after accept until the cycle after RESP. A request held across a busy period is accepted on the first cycle back in IDLE.
- ld_req while busy: ignored. The processor must hold it; the decoder does not latch it.
- rst asserted mid-transaction (WAIT or RESP): return to IDLE next edge, all outputs at reset values, no ld_valid. A tgt_ack arriving in the reset cycle is discarded.
- tgt_addr subtraction is ADDR_W bits wide and cannot underflow, because it is computed only for matched regions.

Optional Feature:
- Macro: LDR_TIMEOUT_EN.
- Defined: an 8-bit counter is cleared on entry to WAIT and increments each WAIT cycle without ack. When it reaches TIMEOUT-1 with still no ack:
  - drop tgt_req and tgt_sel;
  - go to RESP with ld_err=1, ld_data=0, ld_region=i.
  - An ack arriving in that same cycle takes priority and produces a normal response.
- Undefined: no counter; WAIT lasts until ack or reset.

Test Plan:
- ld_addr=0x0000_0010, target0 acks 1 cycle after tgt_req with 0xDEADBEEF -> tgt_sel=2'b01, tgt_addr=0x10; ld_valid one cycle, ld_data=0xDEADBEEF, ld_err=0, ld_region=0.
- ld_addr=1036 and ld_addr=1039, target1 data 0x41 -> tgt_sel=2'b10, tgt_addr=0 and 3 respectively, ld_data=0x41. Boundary addresses 1023 -> region0, 1024 -> unmapped, 1040 -> unmapped.
- ld_addr=1030 (unmapped) -> ld_valid in the cycle after accept, ld_err=1, ld_data=0, ld_region=all-ones, tgt_req never asserted.
- In WAIT for target1, pulse tgt_ack=2'b01 (wrong target), then 2'b10 three cycles later -> the first pulse is ignored; response carries target1 data.
- With LDR_TIMEOUT_EN, TIMEOUT=16, no ack -> after 16 WAIT cycles: ld_err=1, ld_region=1, tgt_req=0. Without the macro the decoder still waits after 100 cycles.
- rst pulsed for 1 cycle during WAIT -> next cycle ld_ready=1, tgt_req=0, no ld_valid; a following load to 0x4 completes normally.
